// File: rtl/dec_pkg.sv
// Decode-stage package: RISC-V major opcodes and the instruction format code.
package dec_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;  // RV64 only
  localparam logic [6:0] OP_OP32   = 7'b0111011;  // RV64 only

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_t;

endpackage

// File: rtl/dec_stage_if.sv
// Decode-stage handshake bundle: upstream instruction in, decoded bundle out.
// master = the side driving instructions and downstream ready; slave = the stage.
interface dec_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [PC_W-1:0] i_pc;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [PC_W-1:0] o_pc;
  logic [31:0]     o_inst;
  logic [6:0]      o_opcode;
  logic [2:0]      o_funct3;
  logic [6:0]      o_funct7;
  logic [4:0]      o_rd;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [2:0]      o_fmt;
  logic [XLEN-1:0] o_imm;
  logic            o_illegal;

  modport master (
    output i_valid, i_inst, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_pc, o_inst, o_opcode, o_funct3, o_funct7,
           o_rd, o_rs1, o_rs2, o_fmt, o_imm, o_illegal
  );

  modport slave (
    input  i_valid, i_inst, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_pc, o_inst, o_opcode, o_funct3, o_funct7,
           o_rd, o_rs1, o_rs2, o_fmt, o_imm, o_illegal
  );
endinterface

// File: rtl/dec_imm.sv
// Combinational format classifier and immediate generator.
// Every mapped opcode ends in 2'b11, so a bad inst[1:0] lands in the NONE/illegal arm.
module dec_imm
  import dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  // Classify the opcode, then place immediate bits and sign-extend from inst[31].
  always_comb begin
    case (inst[6:0])
      OP_OP:                                          fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  fmt = FMT_I;
      OP_STORE:                                       fmt = FMT_S;
      OP_BRANCH:                                      fmt = FMT_B;
      OP_LUI, OP_AUIPC:                               fmt = FMT_U;
      OP_JAL:                                         fmt = FMT_J;
      OP_IMM32:                                       fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      OP_OP32:                                        fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
      default:                                        fmt = FMT_NONE;
    endcase

    illegal = (fmt == FMT_NONE);

    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'h000};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase

    // Widen to XLEN: fill with the 32-bit sign, then overlay the low word.
    imm        = {XLEN{imm32[31]}};
    imm[31:0]  = imm32;
  end

endmodule

// File: rtl/dec_stage.sv
// Registered RV32/RV64 decode stage with valid/ready handshake and flush.
// Optional DEC_SKID_EN: adds a one-entry skid register so o_ready comes from a
// flop with no combinational path from i_ready.
module dec_stage
  import dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  dec_stage_if.slave bus
);

  // Payload carried per bundle: pc, raw inst, format, immediate, illegal.
  localparam int PW = PC_W + 32 + 3 + XLEN + 1;

  fmt_t            dec_fmt;
  logic [XLEN-1:0] dec_imm_val;
  logic            dec_illegal;
  logic [PW-1:0]   in_pay;
  logic [PW-1:0]   out_pay_reg;
  logic            out_valid_reg;
  logic            ready;
  logic            in_xfer;
  logic            out_xfer;

  dec_imm #(.XLEN(XLEN)) u_dec_imm (
    .inst    (bus.i_inst),
    .fmt     (dec_fmt),
    .imm     (dec_imm_val),
    .illegal (dec_illegal)
  );

  assign in_pay   = {bus.i_pc, bus.i_inst, dec_fmt, dec_imm_val, dec_illegal};
  assign in_xfer  = bus.i_valid & ready;
  assign out_xfer = out_valid_reg & bus.i_ready;

`ifdef DEC_SKID_EN
  logic          skid_valid_reg;
  logic [PW-1:0] skid_pay_reg;

  assign ready = ~skid_valid_reg;

  // Skid slot catches an input accepted while the output is stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      skid_valid_reg <= 1'b0;
      skid_pay_reg   <= '0;
    end else if (bus.i_flush) begin
      skid_valid_reg <= 1'b0;
    end else if (out_valid_reg && !bus.i_ready && in_xfer) begin
      skid_valid_reg <= 1'b1;
      skid_pay_reg   <= in_pay;
    end else if (!out_valid_reg || out_xfer) begin
      skid_valid_reg <= 1'b0;
    end
  end

  // Output slot refills from the skid entry first to keep FIFO order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid_reg <= 1'b0;
      out_pay_reg   <= '0;
    end else if (bus.i_flush) begin
      out_valid_reg <= 1'b0;
    end else if (!out_valid_reg || out_xfer) begin
      if (skid_valid_reg) begin
        out_valid_reg <= 1'b1;
        out_pay_reg   <= skid_pay_reg;
      end else if (in_xfer) begin
        out_valid_reg <= 1'b1;
        out_pay_reg   <= in_pay;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end
`else
  assign ready = ~out_valid_reg | bus.i_ready;

  // Single output register: flush wins, then load, then drain on output transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid_reg <= 1'b0;
      out_pay_reg   <= '0;
    end else if (bus.i_flush) begin
      out_valid_reg <= 1'b0;
    end else if (in_xfer) begin
      out_valid_reg <= 1'b1;
      out_pay_reg   <= in_pay;
    end else if (out_xfer) begin
      out_valid_reg <= 1'b0;
    end
  end
`endif

  assign bus.o_ready = ready;
  assign bus.o_valid = out_valid_reg;
  assign {bus.o_pc, bus.o_inst, bus.o_fmt, bus.o_imm, bus.o_illegal} = out_pay_reg;

  // Field outputs are raw slices of the registered instruction, even when illegal.
  assign bus.o_opcode = bus.o_inst[6:0];
  assign bus.o_funct3 = bus.o_inst[14:12];
  assign bus.o_funct7 = bus.o_inst[31:25];
  assign bus.o_rd     = bus.o_inst[11:7];
  assign bus.o_rs1    = bus.o_inst[19:15];
  assign bus.o_rs2    = bus.o_inst[24:20];

endmodule

// File: tb/tb_dec_stage.sv
// Testbench for dec_stage: directed cases plus randomized valid/ready/flush
// streams checked against a queue-based reference model.
// Build with +define+DEC_SKID_EN to exercise the skid variant at XLEN=64.
module tb_dec_stage;

`ifdef DEC_SKID_EN
  localparam int  XLEN = 64;
  localparam bit  SKID = 1'b1;
`else
  localparam int  XLEN = 32;
  localparam bit  SKID = 1'b0;
`endif
  localparam bit  X64  = (XLEN == 64);
  localparam int  PC_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  dec_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Spec-level decode: format from opcode table, immediates by standard placement.
  function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] f,
                                  output logic [63:0] im, output logic ill);
    logic [6:0]         op;
    logic signed [63:0] s;
    op  = ins[6:0];
    s   = 64'sd0;
    ill = 1'b0;
    if (op == 7'h33 || (X64 && op == 7'h3B)) f = 3'd0;
    else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || op == 7'h0F ||
             (X64 && op == 7'h1B)) begin
      f = 3'd1; s = $signed(ins[31:20]);
    end else if (op == 7'h23) begin
      f = 3'd2; s = $signed({ins[31:25], ins[11:7]});
    end else if (op == 7'h63) begin
      f = 3'd3; s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    end else if (op == 7'h37 || op == 7'h17) begin
      f = 3'd4; s = $signed({ins[31:12], 12'h000});
    end else if (op == 7'h6F) begin
      f = 3'd5; s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
    end else begin
      f = 3'd7; ill = 1'b1;
    end
    im = s;
    if (!X64) im[63:32] = 32'h0;
  endfunction

  // Spec constant sign-extended to the configured XLEN.
  function automatic logic [63:0] xl(input logic [31:0] v);
    return X64 ? {{32{v[31]}}, v} : {32'h0, v};
  endfunction

  task automatic check_outputs(input string tag);
    logic [2:0]  f;
    logic [63:0] im;
    logic        ill;
    logic        mrdy;
    mrdy = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || bus.i_ready);
    chk({tag, ".ready"}, 64'(bus.o_ready), 64'(mrdy));
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      ref_dec(exp_q[0].inst, f, im, ill);
      chk({tag, ".pc"},      64'(bus.o_pc),     64'(exp_q[0].pc));
      chk({tag, ".inst"},    64'(bus.o_inst),   64'(exp_q[0].inst));
      chk({tag, ".opcode"},  64'(bus.o_opcode), 64'(exp_q[0].inst[6:0]));
      chk({tag, ".funct3"},  64'(bus.o_funct3), 64'(exp_q[0].inst[14:12]));
      chk({tag, ".funct7"},  64'(bus.o_funct7), 64'(exp_q[0].inst[31:25]));
      chk({tag, ".rd"},      64'(bus.o_rd),     64'(exp_q[0].inst[11:7]));
      chk({tag, ".rs1"},     64'(bus.o_rs1),    64'(exp_q[0].inst[19:15]));
      chk({tag, ".rs2"},     64'(bus.o_rs2),    64'(exp_q[0].inst[24:20]));
      chk({tag, ".fmt"},     64'(bus.o_fmt),    64'(f));
      chk({tag, ".imm"},     64'(bus.o_imm),    im);
      chk({tag, ".illegal"}, 64'(bus.o_illegal), 64'(ill));
    end
  endtask

  // One cycle: drive at negedge, check, advance model at posedge, return at negedge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic fl, input logic rdy);
    logic  mrdy, in_x, out_x;
    item_t it;
    bus.i_valid = v;
    bus.i_inst  = ins;
    bus.i_pc    = pc;
    bus.i_flush = fl;
    bus.i_ready = rdy;
    #1;
    check_outputs(tag);
    mrdy  = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || rdy);
    in_x  = v && mrdy;
    out_x = (exp_q.size() > 0) && rdy;
    if (out_x)
      $display("xfer %s pc=%h inst=%h fmt=%0d imm=%h ill=%0d", tag, bus.o_pc, bus.o_inst,
               bus.o_fmt, bus.o_imm, bus.o_illegal);
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (out_x) void'(exp_q.pop_front());
      if (in_x) begin
        it.pc   = pc;
        it.inst = ins;
        exp_q.push_back(it);
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_front(input string tag, input logic [2:0] f, input logic [63:0] im,
                              input logic [4:0] rd, input logic ill);
    chk({tag, ".x_valid"}, 64'(bus.o_valid),   64'd1);
    chk({tag, ".x_fmt"},   64'(bus.o_fmt),     64'(f));
    chk({tag, ".x_imm"},   64'(bus.o_imm),     im);
    chk({tag, ".x_rd"},    64'(bus.o_rd),      64'(rd));
    chk({tag, ".x_ill"},   64'(bus.o_illegal), 64'(ill));
  endtask

  logic [6:0] op_tab [0:12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h3B};

  initial begin
    logic [31:0] ins;
    bus.i_valid = 1'b0;
    bus.i_inst  = 32'h0;
    bus.i_pc    = 32'h0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid",   64'(bus.o_valid),   64'd0);
    chk("rst.fmt",     64'(bus.o_fmt),     64'd0);
    chk("rst.illegal", 64'(bus.o_illegal), 64'd0);
    chk("rst.imm",     64'(bus.o_imm),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.ready", 64'(bus.o_ready), 64'd1);
    @(negedge clk);

    // addi x1,x0,-1
    step("addi", 1, 32'hFFF00093, 32'h100, 0, 1);
    expect_front("addi", 3'd1, xl(32'hFFFFFFFF), 5'd1, 0);
    chk("addi.rs1", 64'(bus.o_rs1), 64'd0);

    // back-to-back sw, beq, lui, jal
    step("sw",  1, 32'h0020A423, 32'h104, 0, 1);
    expect_front("sw", 3'd2, xl(32'h8), 5'd8, 0);
    step("beq", 1, 32'hFE000EE3, 32'h108, 0, 1);
    expect_front("beq", 3'd3, xl(32'hFFFFFFFC), 5'd29, 0);
    step("lui", 1, 32'h123452B7, 32'h10C, 0, 1);
    expect_front("lui", 3'd4, xl(32'h12345000), 5'd5, 0);
    step("jal", 1, 32'h001000EF, 32'h110, 0, 1);
    expect_front("jal", 3'd5, xl(32'h00000800), 5'd1, 0);
    step("drain", 0, 32'h0, 32'h0, 0, 1);

    // stall for 3 cycles with i_valid held high
    step("stA", 1, 32'h00500113, 32'h200, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 32'h00600193, 32'h204, 0, 0);
`ifndef DEC_SKID_EN
      chk("stall.ready", 64'(bus.o_ready), 64'd0);
`endif
      chk("stall.inst", 64'(bus.o_inst), 64'h00500113);
    end
    for (int i = 0; i < 3; i++) step("unstall", (i == 0), 32'h00600193, 32'h204, 0, 1);

    // illegal encodings still flow with o_valid=1
    step("ill0", 1, 32'h00000000, 32'h300, 0, 1);
    expect_front("ill0", 3'd7, 64'd0, 5'd0, 1);
    step("ill7f", 1, 32'h0000007F, 32'h304, 0, 1);
    expect_front("ill7f", 3'd7, 64'd0, 5'd0, 1);

    // flush with a same-cycle input transfer while the output is valid
    step("flA", 1, 32'h00700213, 32'h400, 0, 1);
    step("flush", 1, 32'h00800293, 32'h404, 1, 1);
    chk("flush.valid", 64'(bus.o_valid), 64'd0);
    step("postfl", 1, 32'h00900313, 32'h408, 0, 1);
    chk("postfl.inst", 64'(bus.o_inst), 64'h00900313);
    step("drain2", 0, 32'h0, 32'h0, 0, 1);

    // addiw: RV64 decodes it as I, RV32 flags it illegal
    step("addiw", 1, 32'hFFF0009B, 32'h500, 0, 1);
    if (X64) expect_front("addiw", 3'd1, 64'hFFFFFFFFFFFFFFFF, 5'd1, 0);
    else     expect_front("addiw", 3'd7, 64'd0, 5'd1, 1);
    step("drain3", 0, 32'h0, 32'h0, 0, 1);

    // randomized valid/ready/flush stream
    for (int n = 0; n < 400; n++) begin
      ins = $urandom();
      if ($urandom_range(9) < 8) ins[6:0] = op_tab[$urandom_range(12)];
      step("rnd", ($urandom_range(9) < 7), ins, $urandom(),
           ($urandom_range(49) == 0), ($urandom_range(9) < 6));
    end

    // asynchronous reset with a bundle in flight
    step("mrA", 1, 32'h00A00393, 32'h600, 0, 0);
    bus.i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst.valid", 64'(bus.o_valid), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step("postrst", 1, 32'h00B00413, 32'h604, 0, 1);
    step("drain4", 0, 32'h0, 32'h0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dec_stage.md
Name: dec_stage

Overview:
Registered RV32/RV64 instruction decode stage between fetch and register-file read/execute.
- Splits the instruction into fields, classifies its format and generates the sign-extended immediate.
- Flags illegal opcodes.
- Presents the results one cycle later behind a valid/ready handshake, with flush support.
- Generalises the plain field decoder with XLEN-parametrised immediates, format classification, pipelining and backpressure.

Parameters:
XLEN, 32, datapath/immediate width; legal values 32 or 64.
PC_W, 32, program-counter width carried alongside the instruction.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; one clock; reset is asynchronous and active-high
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept an instruction this cycle
i_inst  in  32  instruction word
i_pc  in  PC_W  instruction address
i_flush  in  1  discard held and incoming instruction
o_valid  out  1  decoded bundle valid
i_ready  in  1  downstream accepts bundle
o_pc  out  PC_W  registered PC
o_inst  out  32  registered raw instruction
o_opcode  out  7  inst[6:0]
o_funct3  out  3  inst[14:12]
o_funct7  out  7  inst[31:25]
o_rd  out  5  inst[11:7]
o_rs1  out  5  inst[19:15]
o_rs2  out  5  inst[24:20]
o_fmt  out  3  format code
o_imm  out  XLEN  sign-extended immediate
o_illegal  out  1  unrecognised opcode

Behaviour:
- Reset (async assert, sync release): every output register is 0. o_valid=0; o_fmt=0; o_illegal=0. o_ready=1 once reset is released.
- Transfers:
  - Input transfer: i_valid & o_ready.
  - Output transfer: o_valid & i_ready.
  - Latency is 1 cycle from input transfer to o_valid.
- Base mode: o_ready = ~o_valid | i_ready. This is combinational from i_ready.
- Output register loads only on an input transfer.
  - If an output transfer occurs with no input transfer, o_valid drops to 0.
  - While o_valid=1 and i_ready=0, every output is held stable.
- Format codes: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- Opcode map:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - When XLEN=64, also 0011011 -> I and 0111011 -> R.
- Immediates use standard RISC-V bit placement, sign bit inst[31], sign-extended to XLEN.
  - R and NONE: imm=0.
  - U: inst[31:12]<<12, then sign-extended.
- Illegal: inst[1:0]!=2'b11 or opcode not in the map.
  - Sets o_fmt=NONE, o_imm=0, o_illegal=1.
  - The bundle still flows with o_valid=1 so the trap logic sees it.
  - Field outputs stay raw slices.
- Flush: i_flush=1 forces o_valid=0 next cycle.
  - Any same-cycle input transfer is discarded.
  - Flush has priority over load.
  - o_ready stays asserted during flush.
- Reset mid-stream: the in-flight bundle is lost; there is no replay.

Optional Feature:
DEC_SKID_EN
- Defined: a one-entry skid register is added and o_ready is driven from a flop, o_ready = ~skid_valid, with no combinational path from i_ready.
  - An input accepted while the output is stalled goes into the skid register.
  - On the next output transfer the skid entry moves to the output.
  - Ordering is strictly FIFO.
  - i_flush clears both entries.
  - Throughput is 1 per cycle.
- Undefined: base mode as above, with a combinational ready path.

Decomposition:
- dec_pkg holds:
  - opcode localparams (OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE, OP_IMM32, OP_OP32);
  - the fmt_t 3-bit enum with its values.
- One combinational sub-module, dec_imm (inst, XLEN -> fmt, imm, illegal), instantiated ahead of the stage register.

Test Plan:
1. XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> next cycle: o_valid=1, fmt=I, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
2. Back-to-back 0x0020A423 (sw), 0xFE000EE3 (beq -4), 0x123452B7 (lui), 0x001000EF (jal) with i_ready=1 -> four consecutive valid bundles in order:
   - sw: S, imm=8.
   - beq: B, imm=0xFFFFFFFC.
   - lui: U, imm=0x12345000, rd=5.
   - jal: J, imm=0x00000800, rd=1.
3. Hold i_ready=0 for 3 cycles with i_valid=1 -> outputs stable, o_ready=0 (base mode), no instruction lost or duplicated after i_ready=1.
4. 0x00000000 and 0x0000007F -> o_valid=1, o_illegal=1, fmt=7, imm=0.
5. i_flush together with an input transfer while o_valid=1 -> o_valid=0 next cycle, the flushed instruction never appears, and the next instruction decodes normally.
6. DEC_SKID_EN, XLEN=64:
   - Random i_valid/i_ready streams -> exact in-order delivery and o_ready independent of same-cycle i_ready.
   - 0xFFF0009B (addiw) -> fmt=I, imm=0xFFFFFFFFFFFFFFFF.
